// File: rtl/iobuf_seq_pkg.sv
// -----------------------------------------------------------------------------
// iobuf_seq_pkg
// Shared definitions for the IOBUF pad-bus sequencer:
//   - seq_state_e : FSM state encoding (IDLE / DRIVE / TURN)
//   - CNT_W       : width of the hold / turnaround down-counter
//   - cnt_load()  : converts a cycle count into a down-counter load value
// -----------------------------------------------------------------------------
package iobuf_seq_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_TURN  = 2'd2
   } seq_state_e;

   // The counter runs down to zero, so N cycles of a phase load N-1.
   // A zero-cycle phase never loads the counter; return 0 to keep it defined.
   function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
      logic [CNT_W-1:0] load_v;
      if (cycles > 0) begin
         load_v = CNT_W'(cycles - 1);
      end else begin
         load_v = {CNT_W{1'b0}};
      end
      return load_v;
   endfunction

endpackage

// File: rtl/iobuf_rr_arbiter.sv
// -----------------------------------------------------------------------------
// iobuf_rr_arbiter
// Combinational round-robin pick. The winner is the first set request bit at
// or after the pointer, wrapping from NREQ-1 back to 0.
// Ports:
//   req      in  NREQ   request vector
//   ptr      in  IDX_W  highest-priority index this round
//   win_hot  out NREQ   one-hot winner (all zero when no request)
//   win_idx  out IDX_W  binary index of the winner (0 when no request)
//   win_any  out 1      at least one request is set
// -----------------------------------------------------------------------------
module iobuf_rr_arbiter
   import iobuf_seq_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  win_hot,
   output logic [IDX_W-1:0] win_idx,
   output logic             win_any
);

   // Scan NREQ candidates starting at ptr; the first requester found wins.
   always_comb begin : pick
      int   cand_v;
      logic found_v;
      win_hot = {NREQ{1'b0}};
      win_idx = {IDX_W{1'b0}};
      found_v = 1'b0;
      cand_v  = 0;
      for (int i = 0; i < NREQ; i++) begin
         // ptr is always < NREQ, so a single wrap subtraction is enough
         cand_v = int'(ptr) + i;
         if (cand_v >= NREQ) begin
            cand_v = cand_v - NREQ;
         end else begin
            cand_v = cand_v;
         end
         if (!found_v && req[cand_v]) begin
            found_v         = 1'b1;
            win_hot[cand_v] = 1'b1;
            win_idx         = IDX_W'(cand_v);
         end else begin
            found_v = found_v;
         end
      end
      win_any = found_v;
   end

endmodule

// File: rtl/iobuf_bus_sequencer.sv
// -----------------------------------------------------------------------------
// iobuf_bus_sequencer
// Sequences a WIDTH-bit bidirectional pad bus built from per-bit IOBUF cells.
// NREQ transmit requesters share the bus round-robin; every granted word is
// driven for HOLD cycles, followed by TA_CYC all-tristate turnaround cycles
// and at least one IDLE cycle, in which the pads are sampled as receive data.
// Ports:
//   C       in  1           clock, rising edge
//   CLR     in  1           asynchronous active-high reset
//   REQ     in  NREQ        per-requester transmit request (level)
//   WDATA   in  NREQ*WIDTH  requester k word at [k*WIDTH +: WIDTH]
//   GNT     out NREQ        one-hot single-cycle grant pulse
//   PAD_I   out WIDTH       to IOBUF I pins
//   PAD_T   out WIDTH       to IOBUF T pins, 1 = tristate
//   PAD_O   in  WIDTH       from IOBUF O pins
//   RDATA   out WIDTH       captured receive word
//   RVALID  out 1           RDATA updated this cycle
//   BUSY    out 1           sequencer is not IDLE
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module iobuf_bus_sequencer
   import iobuf_seq_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NREQ   = 2,
   parameter int HOLD   = 1,
   parameter int TA_CYC = 2
) (
   input  logic                   C,
   input  logic                   CLR,
   input  logic [NREQ-1:0]        REQ,
   input  logic [NREQ*WIDTH-1:0]  WDATA,
   output logic [NREQ-1:0]        GNT,
   output logic [WIDTH-1:0]       PAD_I,
   output logic [WIDTH-1:0]       PAD_T,
   input  logic [WIDTH-1:0]       PAD_O,
   output logic [WIDTH-1:0]       RDATA,
   output logic                   RVALID,
   output logic                   BUSY
);

   localparam int               IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = cnt_load(HOLD);
   localparam logic [CNT_W-1:0] TA_LOAD   = cnt_load(TA_CYC);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);

   seq_state_e        state_r,  state_nxt_s;
   logic [CNT_W-1:0]  cnt_r,    cnt_nxt_s;
   logic [IDX_W-1:0]  ptr_r,    ptr_nxt_s;
   logic [NREQ-1:0]   gnt_r,    gnt_nxt_s;
   logic [WIDTH-1:0]  pad_i_r,  pad_i_nxt_s;
   logic              tri_r,    tri_nxt_s;
   logic [WIDTH-1:0]  rdata_r,  rdata_nxt_s;
   logic              rvalid_r, rvalid_nxt_s;
   logic              busy_r,   busy_nxt_s;

   logic [NREQ-1:0]   win_hot_s;
   logic [IDX_W-1:0]  win_idx_s;
   logic              win_any_s;
   logic [IDX_W-1:0]  ptr_adv_s;

   iobuf_rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req     (REQ),
      .ptr     (ptr_r),
      .win_hot (win_hot_s),
      .win_idx (win_idx_s),
      .win_any (win_any_s)
   );

   // Pointer moves to the slot after the winner, wrapping at NREQ-1.
   always_comb begin
      if (win_idx_s == LAST_IDX) begin
         ptr_adv_s = {IDX_W{1'b0}};
      end else begin
         ptr_adv_s = win_idx_s + IDX_W'(1);
      end
   end

   // Next-state and next-output logic for the IDLE/DRIVE/TURN sequencer.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      ptr_nxt_s    = ptr_r;
      gnt_nxt_s    = {NREQ{1'b0}};
      pad_i_nxt_s  = pad_i_r;
      tri_nxt_s    = tri_r;
      rdata_nxt_s  = rdata_r;
      rvalid_nxt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // Bus is tristated for the whole IDLE cycle, so the pads are
            // sampled even on the edge that starts a new burst.
            rdata_nxt_s  = PAD_O;
            rvalid_nxt_s = 1'b1;
            if (win_any_s) begin
               state_nxt_s = ST_DRIVE;
               gnt_nxt_s   = win_hot_s;
               pad_i_nxt_s = WDATA[int'(win_idx_s) * WIDTH +: WIDTH];
               tri_nxt_s   = 1'b0;
               ptr_nxt_s   = ptr_adv_s;
               cnt_nxt_s   = HOLD_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
               tri_nxt_s   = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               tri_nxt_s = 1'b1;
               if (TA_CYC > 0) begin
                  state_nxt_s = ST_TURN;
                  cnt_nxt_s   = TA_LOAD;
               end else begin
                  state_nxt_s = ST_IDLE;
                  cnt_nxt_s   = {CNT_W{1'b0}};
               end
            end else begin
               tri_nxt_s = 1'b0;
               cnt_nxt_s = cnt_r - CNT_W'(1);
            end
         end
         ST_TURN: begin
            // Requests are ignored here; PAD_I keeps its stale value.
            tri_nxt_s = 1'b1;
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_nxt_s = ST_IDLE;
            end else begin
               cnt_nxt_s = cnt_r - CNT_W'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
            tri_nxt_s   = 1'b1;
         end
      endcase
      busy_nxt_s = (state_nxt_s != ST_IDLE);
   end

   // State, counter, pointer and all output registers; CLR releases the bus at once.
   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         ptr_r    <= {IDX_W{1'b0}};
         gnt_r    <= {NREQ{1'b0}};
         pad_i_r  <= {WIDTH{1'b0}};
         tri_r    <= 1'b1;
         rdata_r  <= {WIDTH{1'b0}};
         rvalid_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         ptr_r    <= ptr_nxt_s;
         gnt_r    <= gnt_nxt_s;
         pad_i_r  <= pad_i_nxt_s;
         tri_r    <= tri_nxt_s;
         rdata_r  <= rdata_nxt_s;
         rvalid_r <= rvalid_nxt_s;
         busy_r   <= busy_nxt_s;
      end
   end

   // One tristate flop fans out to every T pin so all bits switch together.
   assign PAD_T  = {WIDTH{tri_r}};
   assign GNT    = gnt_r;
   assign PAD_I  = pad_i_r;
   assign RDATA  = rdata_r;
   assign RVALID = rvalid_r;
   assign BUSY   = busy_r;

endmodule

// File: tb/tb_iobuf_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_iobuf_bus_sequencer
// Directed bench for iobuf_bus_sequencer. Three instances:
//   dut_a : defaults (WIDTH 8, NREQ 2, HOLD 1, TA_CYC 2)
//   dut_b : HOLD 3, TA_CYC 0
//   dut_c : NREQ 1
// Expected grants for dut_a are queued when requests are raised and popped
// when a grant pulse appears.
// -----------------------------------------------------------------------------
module tb_iobuf_bus_sequencer;

   logic clk;
   logic clr;

   logic [1:0]  req_a;
   logic [15:0] wdata_a;
   logic [1:0]  gnt_a;
   logic [7:0]  pad_i_a, pad_t_a, pad_o_a, rdata_a;
   logic        rvalid_a, busy_a;

   logic [1:0]  req_b;
   logic [15:0] wdata_b;
   logic [1:0]  gnt_b;
   logic [7:0]  pad_i_b, pad_t_b, pad_o_b, rdata_b;
   logic        rvalid_b, busy_b;

   logic [0:0]  req_c;
   logic [7:0]  wdata_c;
   logic [0:0]  gnt_c;
   logic [7:0]  pad_i_c, pad_t_c, pad_o_c, rdata_c;
   logic        rvalid_c, busy_c;

   typedef struct {
      logic [1:0] gnt;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   gap;

   iobuf_bus_sequencer #(.WIDTH(8), .NREQ(2), .HOLD(1), .TA_CYC(2)) dut_a (
      .C(clk), .CLR(clr), .REQ(req_a), .WDATA(wdata_a), .GNT(gnt_a),
      .PAD_I(pad_i_a), .PAD_T(pad_t_a), .PAD_O(pad_o_a), .RDATA(rdata_a),
      .RVALID(rvalid_a), .BUSY(busy_a));

   iobuf_bus_sequencer #(.WIDTH(8), .NREQ(2), .HOLD(3), .TA_CYC(0)) dut_b (
      .C(clk), .CLR(clr), .REQ(req_b), .WDATA(wdata_b), .GNT(gnt_b),
      .PAD_I(pad_i_b), .PAD_T(pad_t_b), .PAD_O(pad_o_b), .RDATA(rdata_b),
      .RVALID(rvalid_b), .BUSY(busy_b));

   iobuf_bus_sequencer #(.WIDTH(8), .NREQ(1), .HOLD(1), .TA_CYC(2)) dut_c (
      .C(clk), .CLR(clr), .REQ(req_c), .WDATA(wdata_c), .GNT(gnt_c),
      .PAD_I(pad_i_c), .PAD_T(pad_t_c), .PAD_O(pad_o_c), .RDATA(rdata_c),
      .RVALID(rvalid_c), .BUSY(busy_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next grant pulse on dut_a (at most bound cycles), then
   // compare it against the oldest queued expectation. gap = cycles waited.
   task automatic expect_grant(input string tag, input int bound);
      exp_t e;
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (gnt_a == 2'b00 && gap < bound);
      chk({tag, "_seen"}, {31'd0, gnt_a != 2'b00}, 32'd1);
      if (gnt_a != 2'b00) begin
         chk({tag, "_sb_nonempty"}, {31'd0, sb_q.size() != 0}, 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_gnt"}, {30'd0, gnt_a}, {30'd0, e.gnt});
            chk({tag, "_pad_i"}, {24'd0, pad_i_a}, {24'd0, e.data});
            chk({tag, "_pad_t"}, {24'd0, pad_t_a}, 32'h0000_0000);
            chk({tag, "_busy"}, {31'd0, busy_a}, 32'd1);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clr = 1'b1;
      req_a = 2'b00; wdata_a = 16'h0000; pad_o_a = 8'h00;
      req_b = 2'b00; wdata_b = 16'h0000; pad_o_b = 8'h00;
      req_c = 1'b0;  wdata_c = 8'h00;    pad_o_c = 8'h00;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_pad_t",  {24'd0, pad_t_a}, 32'h0000_00FF);
      chk("rst_pad_i",  {24'd0, pad_i_a}, 32'h0000_0000);
      chk("rst_gnt",    {30'd0, gnt_a},   32'h0000_0000);
      chk("rst_rvalid", {31'd0, rvalid_a}, 32'd0);
      chk("rst_rdata",  {24'd0, rdata_a}, 32'h0000_0000);
      chk("rst_busy",   {31'd0, busy_a},  32'd0);
      clr = 1'b0;

      // receive while idle
      pad_o_a = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rx_rvalid", {31'd0, rvalid_a}, 32'd1);
         chk("rx_rdata",  {24'd0, rdata_a},  32'h0000_003C);
         chk("rx_pad_t",  {24'd0, pad_t_a},  32'h0000_00FF);
         chk("rx_busy",   {31'd0, busy_a},   32'd0);
      end

      // single request
      wdata_a[7:0] = 8'hA5;
      req_a = 2'b01;
      sb_q.push_back('{gnt: 2'b01, data: 8'hA5});
      expect_grant("single", 8);
      chk("single_latency", gap, 32'd1);
      chk("single_cap_rvalid", {31'd0, rvalid_a}, 32'd1);
      req_a = 2'b00;
      @(negedge clk);
      chk("turn1_gnt",    {30'd0, gnt_a},    32'd0);
      chk("turn1_pad_t",  {24'd0, pad_t_a},  32'h0000_00FF);
      chk("turn1_rvalid", {31'd0, rvalid_a}, 32'd0);
      chk("turn1_busy",   {31'd0, busy_a},   32'd1);
      chk("turn1_pad_i",  {24'd0, pad_i_a},  32'h0000_00A5);
      // requester 1 pulses only while the bus is turning around
      wdata_a[15:8] = 8'h77;
      req_a = 2'b10;
      @(negedge clk);
      chk("turn2_pad_t",  {24'd0, pad_t_a},  32'h0000_00FF);
      chk("turn2_rvalid", {31'd0, rvalid_a}, 32'd0);
      chk("turn2_busy",   {31'd0, busy_a},   32'd1);
      req_a = 2'b00;
      @(negedge clk);
      chk("idle_pad_t", {24'd0, pad_t_a}, 32'h0000_00FF);
      chk("idle_busy",  {31'd0, busy_a},  32'd0);
      chk("idle_gnt",   {30'd0, gnt_a},   32'd0);
      pad_o_a = 8'hC3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wd_gnt",    {30'd0, gnt_a},    32'd0);
         chk("wd_rvalid", {31'd0, rvalid_a}, 32'd1);
         chk("wd_rdata",  {24'd0, rdata_a},  32'h0000_00C3);
      end

      // minimum grant spacing with a held request
      req_a = 2'b01;
      sb_q.push_back('{gnt: 2'b01, data: 8'hA5});
      expect_grant("space0", 8);
      sb_q.push_back('{gnt: 2'b01, data: 8'hA5});
      expect_grant("space1", 8);
      chk("space_gap", gap, 32'd4);

      // CLR in the middle of a burst releases the bus without a clock edge
      #2;
      clr = 1'b1;
      #1;
      chk("clr_pad_t",  {24'd0, pad_t_a},  32'h0000_00FF);
      chk("clr_gnt",    {30'd0, gnt_a},    32'd0);
      chk("clr_rvalid", {31'd0, rvalid_a}, 32'd0);
      chk("clr_rdata",  {24'd0, rdata_a},  32'd0);
      chk("clr_busy",   {31'd0, busy_a},   32'd0);
      req_a = 2'b00;
      @(negedge clk);
      clr = 1'b0;

      // round robin with both requesting
      wdata_a = {8'h22, 8'h11};
      req_a = 2'b11;
      for (int i = 0; i < 2; i++) begin
         sb_q.push_back('{gnt: 2'b01, data: 8'h11});
         sb_q.push_back('{gnt: 2'b10, data: 8'h22});
      end
      expect_grant("rr0", 8);
      for (int i = 1; i < 4; i++) begin
         expect_grant("rr", 8);
         chk("rr_gap", gap, 32'd4);
      end
      req_a = 2'b00;
      chk("sb_drained", sb_q.size(), 32'd0);

      // HOLD=3, TA_CYC=0: three drive cycles, one idle cycle, repeat
      wdata_b[7:0] = 8'h5A;
      req_b = 2'b01;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("b_pad_t",  {24'd0, pad_t_b},  (i % 4 == 3) ? 32'h0000_00FF : 32'h0000_0000);
         chk("b_rvalid", {31'd0, rvalid_b}, (i % 4 == 0) ? 32'd1 : 32'd0);
         chk("b_gnt",    {30'd0, gnt_b},    (i % 4 == 0) ? 32'd1 : 32'd0);
         if (i % 4 != 3) begin
            chk("b_pad_i", {24'd0, pad_i_b}, 32'h0000_005A);
         end
      end
      req_b = 2'b00;

      // NREQ=1: every grant goes to requester 0
      wdata_c = 8'h96;
      req_c = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("c_gnt", {31'd0, gnt_c}, (i % 4 == 0) ? 32'd1 : 32'd0);
         if (i % 4 == 0) begin
            chk("c_pad_i", {24'd0, pad_i_c}, 32'h0000_0096);
         end
      end
      req_c = 1'b0;

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
